ipml_fifo_wr_packer: RTL



---
 rtl/ipml_wr_obuf.sv | 56 +++++
 rtl/ipml_fifo_wr_packer.sv | 83 ++++++++
 2 files changed

// File: rtl/ipml_wr_obuf.sv
// Two-entry register FIFO between the packer and the FIFO write port.
// The head is always entry 0, so the consumer sees a registered word with no read mux.
module ipml_wr_obuf #(
  parameter int W = 36
) (
  input  logic         wr_clk,
  input  logic         wr_rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   cnt
);

  logic [W-1:0] mem_reg [2];
  logic [1:0]   cnt_reg;
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push & (cnt_reg != 2'd2);
  assign pop_ok  = pop & (cnt_reg != 2'd0);

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
      cnt_reg    <= 2'd0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          mem_reg[cnt_reg[0]] <= din;
          cnt_reg             <= cnt_reg + 2'd1;
        end
        2'b01: begin
          // Shift down and zero the vacated slot so an empty buffer reads as 0
          mem_reg[0] <= mem_reg[1];
          mem_reg[1] <= '0;
          cnt_reg    <= cnt_reg - 2'd1;
        end
        2'b11: begin
          if (cnt_reg == 2'd1) begin
            mem_reg[0] <= din;
          end else begin
            mem_reg[0] <= mem_reg[1];
            mem_reg[1] <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = mem_reg[0];
  assign cnt  = cnt_reg;

endmodule

// File: rtl/ipml_fifo_wr_packer.sv
// Packs RATIO narrow valid/ready beats into one FIFO write word with a lane keep mask.
// s_ready depends only on registered buffer occupancy, never on the FIFO's wr_vld.
module ipml_fifo_wr_packer #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic [IN_W-1:0]       s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [IN_W*RATIO-1:0] fifo_wr_data,
  output logic [RATIO-1:0]      fifo_wr_keep,
  output logic                  fifo_wr_en,
  input  logic                  fifo_wr_vld,
  output logic                  busy
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  function automatic logic [CNT_W-1:0] lane_of(input logic [CNT_W-1:0] c);
    if (LSB_FIRST != 0) return c;
    return CNT_W'(RATIO - 1) - c;
  endfunction

  logic [CNT_W-1:0]       cnt_reg;
  logic [OUT_W-1:0]       acc_reg;
  logic [RATIO-1:0]       keep_reg;
  logic [OUT_W-1:0]       acc_next;
  logic [RATIO-1:0]       keep_next;
  logic [CNT_W-1:0]       lane;
  logic                   accept;
  logic                   complete;
  logic [1:0]             obuf_cnt;
  logic [OUT_W+RATIO-1:0] obuf_dout;

  assign s_ready  = ~wr_rst & (obuf_cnt != 2'd2);
  assign accept   = s_valid & s_ready;
  assign lane     = lane_of(cnt_reg);
  assign complete = accept & ((cnt_reg == CNT_W'(RATIO - 1)) | s_last);

  // Merge the incoming beat into its lane; the pushed word is this merged view
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    logic lane_hit;
    assign lane_hit = accept & (lane == CNT_W'(gi));
    assign acc_next[gi*IN_W +: IN_W] = lane_hit ? s_data : acc_reg[gi*IN_W +: IN_W];
    assign keep_next[gi] = keep_reg[gi] | lane_hit;
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst || complete) begin
      cnt_reg  <= '0;
      acc_reg  <= '0;
      keep_reg <= '0;
    end else if (accept) begin
      cnt_reg  <= cnt_reg + CNT_W'(1);
      acc_reg  <= acc_next;
      keep_reg <= keep_next;
    end
  end

  ipml_wr_obuf #(
    .W (OUT_W + RATIO)
  ) u_obuf (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .push   (complete),
    .pop    (fifo_wr_en),
    .din    ({keep_next, acc_next}),
    .dout   (obuf_dout),
    .cnt    (obuf_cnt)
  );

  // Reset gates the outputs so nothing leaks out during the reset cycle itself
  assign fifo_wr_en   = ~wr_rst & (obuf_cnt != 2'd0) & fifo_wr_vld;
  assign fifo_wr_data = wr_rst ? '0 : obuf_dout[OUT_W-1:0];
  assign fifo_wr_keep = wr_rst ? '0 : obuf_dout[OUT_W+RATIO-1:OUT_W];
  assign busy         = ~wr_rst & ((cnt_reg != '0) | (obuf_cnt != 2'd0));

endmodule
